// File: rtl/wf_player_if.sv
// wf_player_if: signal bundle between the waveform player, its control
// source, the DPBRAM read port and the current-control loop.
//
// Signal groups
//   control : wf_start (level, rising edge starts), wf_stop (level abort),
//             wf_loop, wf_len (1..2**ADDR_W, 0 = no run), wf_div (period)
//   ram     : ram_en / ram_addr toward the DPBRAM, ram_dout back from it
//   output  : wf_data, wf_valid, wf_idx, wf_busy, wf_done
//
// Handshake semantics: there is no ready/backpressure anywhere. wf_valid,
// wf_done and ram_en are single-cycle strobes that the receiver must take
// in the cycle they are high; wf_data/wf_idx stay stable between strobes.
//
// Modports
//   slave  : the player itself
//   master : the environment (controller, RAM model, setpoint consumer)
interface wf_player_if #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 16,
  parameter int DIV_W  = 16
);
  logic              wf_start;
  logic              wf_stop;
  logic              wf_loop;
  logic [ADDR_W:0]   wf_len;
  logic [DIV_W-1:0]  wf_div;

  logic              ram_en;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_dout;

  logic [DATA_W-1:0] wf_data;
  logic              wf_valid;
  logic [ADDR_W-1:0] wf_idx;
  logic              wf_busy;
  logic              wf_done;

  modport slave (
    input  wf_start, wf_stop, wf_loop, wf_len, wf_div, ram_dout,
    output ram_en, ram_addr, wf_data, wf_valid, wf_idx, wf_busy, wf_done
  );

  modport master (
    output wf_start, wf_stop, wf_loop, wf_len, wf_div, ram_dout,
    input  ram_en, ram_addr, wf_data, wf_valid, wf_idx, wf_busy, wf_done
  );
endinterface

// File: rtl/wf_player.sv
// wf_player: waveform playback engine. Reads samples back from the DPBRAM
// read port at a programmable sample period and presents each one as a
// setpoint word with a one-cycle valid strobe. One-shot or looped playback,
// immediate abort via wf_stop.
//
// Ports
//   clk        system clock
//   rst        synchronous reset, active-high
//   bus        wf_player_if.slave (control, DPBRAM read port, setpoint out)
//   dbg_state  current FSM state encoding, for observation only
//
// Timing (start edge sampled in cycle T, RAM latency L, period d):
//   T+1         FETCH, ram_en pulse, address 0, period counter 0
//   T+2..T+1+L  WAIT for read data
//   T+2+L       LATCH, wf_valid strobe with the new sample
//   then HOLD until the period counter wraps, which starts the next FETCH.
module wf_player #(
  parameter int ADDR_W  = 9,
  parameter int DATA_W  = 16,
  parameter int RAM_LAT = 1,
  parameter int DIV_W   = 16
) (
  input  logic         clk,
  input  logic         rst,
  wf_player_if.slave   bus,
  output logic [2:0]   dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_LATCH = 3'd3,
    S_HOLD  = 3'd4
  } state_t;

  // FETCH + RAM_LAT wait cycles + LATCH must fit inside one period.
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(RAM_LAT + 2);
  localparam int WCNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'((RAM_LAT > 0) ? RAM_LAT - 1 : 0);

  state_t            state;
  logic              start_d;
  logic [ADDR_W:0]   len_r;
  logic [DIV_W-1:0]  div_r;
  logic [DIV_W-1:0]  cnt;
  logic [WCNT_W-1:0] wcnt;
  logic [ADDR_W-1:0] addr;

  logic              ram_en_r;
  logic [DATA_W-1:0] data_r;
  logic              valid_r;
  logic [ADDR_W-1:0] idx_r;
  logic              busy_r;
  logic              done_r;

  logic start_edge;
  logic period_end;
  logic last_idx;

  assign start_edge = bus.wf_start & ~start_d;
  assign period_end = (cnt == div_r - 1'b1);
  assign last_idx   = ({1'b0, addr} == (len_r - 1'b1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      start_d  <= 1'b0;
      len_r    <= '0;
      div_r    <= '0;
      cnt      <= '0;
      wcnt     <= '0;
      addr     <= '0;
      ram_en_r <= 1'b0;
      data_r   <= '0;
      valid_r  <= 1'b0;
      idx_r    <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      // Edge detector runs every cycle so a start held through a run
      // cannot look like a fresh edge when the run ends.
      start_d  <= bus.wf_start;
      ram_en_r <= 1'b0;
      valid_r  <= 1'b0;
      done_r   <= 1'b0;

      if (state != S_IDLE && bus.wf_stop) begin
        // Abort: setpoint data/idx keep their last values.
        state  <= S_IDLE;
        busy_r <= 1'b0;
        addr   <= '0;
        cnt    <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            busy_r <= 1'b0;
            addr   <= '0;
            cnt    <= '0;
            if (start_edge && !bus.wf_stop && bus.wf_len != '0) begin
              len_r    <= bus.wf_len;
              div_r    <= (bus.wf_div < MIN_DIV) ? MIN_DIV : bus.wf_div;
              state    <= S_FETCH;
              ram_en_r <= 1'b1;
              busy_r   <= 1'b1;
            end
          end

          default: begin
            if (period_end) begin
              // Period boundary: only reachable from LATCH or HOLD because
              // the period is never shorter than the fetch pipeline.
              cnt <= '0;
              if (last_idx) begin
                if (bus.wf_loop) begin
                  addr     <= '0;
                  state    <= S_FETCH;
                  ram_en_r <= 1'b1;
                end else begin
                  // busy stays high through the done cycle, IDLE drops it.
                  addr   <= '0;
                  state  <= S_IDLE;
                  done_r <= 1'b1;
                end
              end else begin
                addr     <= addr + 1'b1;
                state    <= S_FETCH;
                ram_en_r <= 1'b1;
              end
            end else begin
              cnt <= cnt + 1'b1;
              case (state)
                S_FETCH: begin
                  if (RAM_LAT == 0) begin
                    state   <= S_LATCH;
                    data_r  <= bus.ram_dout;
                    idx_r   <= addr;
                    valid_r <= 1'b1;
                  end else begin
                    state <= S_WAIT;
                    wcnt  <= '0;
                  end
                end
                S_WAIT: begin
                  if (wcnt == WCNT_LAST) begin
                    state   <= S_LATCH;
                    data_r  <= bus.ram_dout;
                    idx_r   <= addr;
                    valid_r <= 1'b1;
                  end else begin
                    wcnt <= wcnt + 1'b1;
                  end
                end
                S_LATCH: state <= S_HOLD;
                default: state <= state;
              endcase
            end
          end
        endcase
      end
    end
  end

  assign bus.ram_en   = ram_en_r;
  assign bus.ram_addr = addr;
  assign bus.wf_data  = data_r;
  assign bus.wf_valid = valid_r;
  assign bus.wf_idx   = idx_r;
  assign bus.wf_busy  = busy_r;
  assign bus.wf_done  = done_r;
  assign dbg_state    = state;

endmodule

// File: tb/tb_wf_player.sv
// tb_wf_player: playback bench for wf_player. Expected fetches, setpoint
// strobes and done pulses are computed from start time, period, length and
// pass count and queued; a negedge monitor pops and compares them.
module tb_wf_player;
  localparam int ADDR_W = 9;
  localparam int DATA_W = 16;
  localparam int DIV_W  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [2:0] dbg_state;
  int cyc = 0;
  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] ram [0:(1<<ADDR_W)-1];

  // {cycle, idx, data} per setpoint strobe
  logic [31+ADDR_W+DATA_W:0] exp_q[$];
  // {cycle, addr} per RAM fetch
  logic [31+ADDR_W:0] fetch_q[$];
  int done_q[$];

  logic [DATA_W-1:0] model_data = '0;
  logic [ADDR_W-1:0] model_idx = '0;

  wf_player_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DIV_W(DIV_W)) bus();

  wf_player #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RAM_LAT(1), .DIV_W(DIV_W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / RAM ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (bus.ram_en) bus.ram_dout <= ram[bus.ram_addr];

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    logic [31+ADDR_W+DATA_W:0] e;
    logic [31+ADDR_W:0] f;
    int dc;
    if (bus.wf_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL valid_unexpected cyc=%0d got idx=%0d data=%0d", cyc, bus.wf_idx, bus.wf_data);
      end else begin
        e = exp_q.pop_front();
        if (e !== {32'(cyc), bus.wf_idx, bus.wf_data}) begin
          failures++;
          $display("FAIL valid_sample got cyc=%0d idx=%0d data=%0d expected cyc=%0d idx=%0d data=%0d",
                   cyc, bus.wf_idx, bus.wf_data, e[31+ADDR_W+DATA_W -: 32],
                   e[ADDR_W+DATA_W-1 -: ADDR_W], e[DATA_W-1:0]);
        end
      end
    end
    if (bus.ram_en) begin
      checks++;
      if (fetch_q.size() == 0) begin
        failures++;
        $display("FAIL fetch_unexpected cyc=%0d addr=%0d", cyc, bus.ram_addr);
      end else begin
        f = fetch_q.pop_front();
        if (f !== {32'(cyc), bus.ram_addr}) begin
          failures++;
          $display("FAIL fetch got cyc=%0d addr=%0d expected cyc=%0d addr=%0d",
                   cyc, bus.ram_addr, f[31+ADDR_W -: 32], f[ADDR_W-1:0]);
        end
      end
    end
    if (bus.wf_done) begin
      checks++;
      if (done_q.size() == 0) begin
        failures++;
        $display("FAIL done_unexpected cyc=%0d", cyc);
      end else begin
        dc = done_q.pop_front();
        if (dc != cyc) begin
          failures++;
          $display("FAIL done_cycle got=%0d expected=%0d", cyc, dc);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  // kind: 0 = run to completion, 1 = stop, 2 = reset. The abort is held for
  // the single cycle t0+1+ab_n*d+ab_off.
  task automatic play(input int len, input int div, input int passes,
                      input int kind, input int ab_n, input int ab_off);
    int d, total, t0, abort_c, done_c, end_c, nf, nv, loop_off;
    bit repulse;
    d = (div < 3) ? 3 : div;
    total = len * passes;
    t0 = cyc;
    done_c = t0 + 1 + total * d;
    abort_c = t0 + 1 + ab_n * d + ab_off;
    nf = total;
    nv = total;
    if (kind != 0) begin
      nf = 0;
      nv = 0;
      for (int n = 0; n < total; n++) begin
        if (t0 + 1 + n * d <= abort_c) nf = n + 1;
        if (t0 + 3 + n * d <= abort_c) nv = n + 1;
      end
    end
    for (int n = 0; n < nf; n++)
      fetch_q.push_back({32'(t0 + 1 + n * d), ADDR_W'(n % len)});
    for (int n = 0; n < nv; n++) begin
      exp_q.push_back({32'(t0 + 3 + n * d), ADDR_W'(n % len), ram[n % len]});
      model_data = ram[n % len];
      model_idx = ADDR_W'(n % len);
    end
    if (kind == 0) done_q.push_back(done_c);
    end_c = (kind == 0) ? done_c + 2 : abort_c + 2;
    repulse = ((kind == 0) ? done_c : abort_c) > t0 + 4;
    loop_off = t0 + 2 + (passes - 1) * len * d;

    bus.wf_len = (ADDR_W+1)'(len);
    bus.wf_div = DIV_W'(div);
    for (int c = t0; c <= end_c; c++) begin
      bus.wf_start = (c == t0) || (repulse && c == t0 + 3);
      bus.wf_loop  = (passes > 1) && (c < loop_off);
      bus.wf_stop  = (kind == 1) && (c == abort_c);
      rst          = (kind == 2) && (c == abort_c);
      if (c == t0 + 1) chk("busy_at_first_fetch", 32'(bus.wf_busy), 32'd1);
      if (kind == 0 && c == done_c) chk("busy_in_done_cycle", 32'(bus.wf_busy), 32'd1);
      if (kind == 0 && c == done_c + 1) begin
        chk("busy_after_done", 32'(bus.wf_busy), 32'd0);
        chk("addr_after_done", 32'(bus.ram_addr), 32'd0);
      end
      if (kind != 0 && c == abort_c + 1) begin
        if (kind == 2) begin
          model_data = '0;
          model_idx = '0;
        end
        chk("busy_after_abort", 32'(bus.wf_busy), 32'd0);
        chk("ram_en_after_abort", 32'(bus.ram_en), 32'd0);
        chk("data_after_abort", 32'(bus.wf_data), 32'(model_data));
      end
      if (c == end_c) begin
        chk("data_hold", 32'(bus.wf_data), 32'(model_data));
        chk("idx_hold", 32'(bus.wf_idx), 32'(model_idx));
      end
      tick();
    end
    bus.wf_start = 1'b0;
    bus.wf_loop = 1'b0;
    bus.wf_stop = 1'b0;
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int len_v, div_v, pass_v, kind_v, abn_v, aboff_v, d_v;
    for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = DATA_W'($urandom);
    ram[0] = 16'd10;
    ram[1] = 16'd20;
    ram[2] = 16'd30;
    ram[3] = 16'd40;

    bus.wf_start = 1'b1;
    bus.wf_stop = 1'b0;
    bus.wf_loop = 1'b0;
    bus.wf_len = 10'd4;
    bus.wf_div = 16'd5;
    rst = 1'b1;
    tick();
    bus.wf_start = 1'b0;
    tick();
    rst = 1'b0;
    chk("reset_data", 32'(bus.wf_data), 32'd0);
    chk("reset_valid", 32'(bus.wf_valid), 32'd0);
    chk("reset_idx", 32'(bus.wf_idx), 32'd0);
    chk("reset_busy", 32'(bus.wf_busy), 32'd0);
    chk("reset_done", 32'(bus.wf_done), 32'd0);
    chk("reset_ram_en", 32'(bus.ram_en), 32'd0);
    chk("reset_ram_addr", 32'(bus.ram_addr), 32'd0);
    repeat (5) tick();
    chk("idle_after_reset_busy", 32'(bus.wf_busy), 32'd0);

    // one-shot, 4 samples, period 5
    play(4, 5, 1, 0, 0, 0);
    repeat (2) tick();
    // loop over 3 samples, period 4, loop dropped during the third pass
    play(3, 4, 3, 0, 0, 0);
    repeat (2) tick();
    // clamped period, stop on second fetch
    play(4, 0, 1, 1, 1, 0);
    chk("stop_data_holds_10", 32'(bus.wf_data), 32'd10);
    repeat (2) tick();

    // zero length start is ignored
    bus.wf_len = '0;
    bus.wf_start = 1'b1;
    tick();
    bus.wf_start = 1'b0;
    repeat (4) tick();
    chk("len0_busy", 32'(bus.wf_busy), 32'd0);

    // stop and start in the same cycle stays idle
    bus.wf_len = 10'd4;
    bus.wf_start = 1'b1;
    bus.wf_stop = 1'b1;
    tick();
    bus.wf_start = 1'b0;
    bus.wf_stop = 1'b0;
    repeat (4) tick();
    chk("stop_start_busy", 32'(bus.wf_busy), 32'd0);

    // reset while holding the first sample, then a fresh run from 0
    play(4, 6, 1, 2, 0, 3);
    chk("after_reset_data", 32'(bus.wf_data), 32'd0);
    repeat (2) tick();
    play(4, 5, 1, 0, 0, 0);
    repeat (2) tick();

    // full table: one-shot, then looped twice (511 -> 0 wrap)
    play(512, 3, 1, 0, 0, 0);
    repeat (2) tick();
    play(512, 3, 2, 0, 0, 0);
    repeat (2) tick();

    for (int r = 0; r < 24; r++) begin
      len_v = $urandom_range(1, 12);
      div_v = $urandom_range(0, 9);
      pass_v = $urandom_range(1, 3);
      kind_v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      d_v = (div_v < 3) ? 3 : div_v;
      abn_v = $urandom_range(0, len_v * pass_v - 1);
      aboff_v = $urandom_range(0, d_v - 1);
      play(len_v, div_v, pass_v, kind_v, abn_v, aboff_v);
      repeat ($urandom_range(1, 3)) tick();
    end

    repeat (4) tick();
    chk("valid_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("fetch_queue_drained", 32'(fetch_q.size()), 32'd0);
    chk("done_queue_drained", 32'(done_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
